// File: rtl/tage_pkg.sv
// tage_pkg
// Definitions shared by the TAGE front end: the global history width, the
// layout of one in-flight branch record, and the history shift helper used
// both here and by the predictor when it forms its own lookup history.
package tage_pkg;

  // Global history width; the predictor's ghr port must use the same width.
  localparam int GHR_W = 32;

  // One in-flight conditional branch: its PC, the speculative history seen
  // just before it was predicted, and the direction the predictor chose.
  typedef struct packed {
    logic [31:0]      pc;
    logic [GHR_W-1:0] ghr_snap;
    logic             pred_taken;
  } tage_hist_entry_t;

  // Append one outcome to a history: the oldest bit falls off the top and
  // the newest outcome enters at bit 0.
  function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] ghr,
                                                 input logic             taken);
    return {ghr[GHR_W-2:0], taken};
  endfunction

endpackage

// File: rtl/tage_hist_fifo.sv
// tage_hist_fifo
// Circular buffer of in-flight branch records, oldest at head.
// The caller guarantees push only when not full and pop only when not empty;
// flush_all drops every entry and takes priority over push and pop.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   push        write push_entry at the tail
//   push_entry  record to store
//   pop         retire the head entry
//   flush_all   discard all entries (head realigned to tail)
//   head_entry  record currently at the head (valid while count != 0)
//   count       number of occupied entries, 0..DEPTH
module tage_hist_fifo
  import tage_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  tage_hist_entry_t         push_entry,
  input  logic                     pop,
  input  logic                     flush_all,
  output tage_hist_entry_t         head_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  tage_hist_entry_t mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_all) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count alone says which slots hold live data.
  // A push cancelled by flush_all is blocked here too so the slot stays clean.
  always_ff @(posedge clk) begin
    if (rst && push && !flush_all) begin
      mem[tail] <= push_entry;
    end
  end

  assign head_entry = mem[head];

endmodule

// File: rtl/tage_hist_queue.sv
// tage_hist_queue
// Speculative global-history manager and in-flight branch queue in front of
// the TAGE predictor. Every predicted conditional branch is recorded with the
// history it was predicted under; in-order resolutions retire those records
// into a registered training stream and repair the speculative history after
// a mispredict or a flush.
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   pred_valid/pc/taken       predicted branch issued by fetch
//   pred_ready                queue not full
//   ghr                       speculative history for predictor lookups
//   resolve_valid/taken       execute resolves the oldest branch
//   flush                     drop all in-flight branches
//   train_en/pc/ghr           registered training strobe and its record
//   actual_taken              resolved direction of the trained branch
//   mispredict                registered pulse: resolved != predicted
//   count                     occupied entries
//
// GHR_W must equal tage_pkg::GHR_W because the stored records use the
// package layout.
module tage_hist_queue #(
  parameter int DEPTH = 8,
  parameter int GHR_W = tage_pkg::GHR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pred_valid,
  input  logic [31:0]            pred_pc,
  input  logic                   pred_taken,
  output logic                   pred_ready,
  output logic [GHR_W-1:0]       ghr,
  input  logic                   resolve_valid,
  input  logic                   resolve_taken,
  input  logic                   flush,
  output logic                   train_en,
  output logic [31:0]            train_pc,
  output logic [GHR_W-1:0]       train_ghr,
  output logic                   actual_taken,
  output logic                   mispredict,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [GHR_W-1:0] spec_ghr;
  logic [GHR_W-1:0] arch_ghr;
  logic [GHR_W-1:0] arch_ghr_next;
  logic [GHR_W-1:0] resolved_ghr;

  tage_pkg::tage_hist_entry_t head_entry;
  tage_pkg::tage_hist_entry_t push_entry;

  logic push_ok;
  logic resolve_ok;
  logic mispredict_now;
  logic discard_all;
  logic fifo_push;

  // Readiness depends only on registered occupancy; a same-cycle pop never
  // frees a slot for a push.
  assign pred_ready = (count != CNT_W'(DEPTH));
  assign push_ok    = pred_valid && pred_ready;
  assign resolve_ok = resolve_valid && (count != '0);

  // History as it stands right after the head branch with its real outcome.
  assign resolved_ghr   = tage_pkg::ghr_shift(head_entry.ghr_snap, resolve_taken);
  assign mispredict_now = resolve_ok && (resolve_taken != head_entry.pred_taken);
  assign arch_ghr_next  = resolve_ok ? resolved_ghr : arch_ghr;

  // Any repair invalidates every younger in-flight branch, including one
  // arriving this very cycle.
  assign discard_all = mispredict_now || flush;
  assign fifo_push   = push_ok && !discard_all;

  assign push_entry.pc         = pred_pc;
  assign push_entry.ghr_snap   = spec_ghr;
  assign push_entry.pred_taken = pred_taken;

  tage_hist_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (resolve_ok),
    .flush_all  (discard_all),
    .head_entry (head_entry),
    .count      (count)
  );

  // Committed history tracks resolved outcomes only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      arch_ghr <= '0;
    end else begin
      arch_ghr <= arch_ghr_next;
    end
  end

  // Speculative history: a flush restores the committed history including
  // this cycle's resolve; a mispredict rebuilds from the bad branch's
  // snapshot plus its real outcome; otherwise each accepted prediction
  // shifts in. On a flush that also mispredicts both repairs agree.
  always_ff @(posedge clk) begin
    if (!rst) begin
      spec_ghr <= '0;
    end else if (flush) begin
      spec_ghr <= arch_ghr_next;
    end else if (mispredict_now) begin
      spec_ghr <= resolved_ghr;
    end else if (push_ok) begin
      spec_ghr <= tage_pkg::ghr_shift(spec_ghr, pred_taken);
    end
  end

  // Training outputs are registered one cycle after the resolve; the data
  // fields hold their last value between strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      train_en     <= 1'b0;
      train_pc     <= '0;
      train_ghr    <= '0;
      actual_taken <= 1'b0;
      mispredict   <= 1'b0;
    end else begin
      train_en   <= resolve_ok;
      mispredict <= mispredict_now;
      if (resolve_ok) begin
        train_pc     <= head_entry.pc;
        train_ghr    <= head_entry.ghr_snap;
        actual_taken <= resolve_taken;
      end
    end
  end

  assign ghr = spec_ghr;

endmodule

// File: tb/tb_tage_hist_queue.sv
// tb_tage_hist_queue
// Directed scenarios followed by randomized traffic, each cycle compared
// against a queue-based reference model of the history manager.
module tb_tage_hist_queue;

  localparam int DEPTH = 8;
  localparam int GHR_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             pred_valid;
  logic [31:0]      pred_pc;
  logic             pred_taken;
  logic             pred_ready;
  logic [GHR_W-1:0] ghr;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             flush;
  logic             train_en;
  logic [31:0]      train_pc;
  logic [GHR_W-1:0] train_ghr;
  logic             actual_taken;
  logic             mispredict;
  logic [3:0]       count;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  typedef struct {
    logic [31:0] pc;
    logic [31:0] snap;
    logic        pt;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_spec;
  logic [31:0] m_arch;
  logic        m_train_en;
  logic [31:0] m_train_pc;
  logic [31:0] m_train_ghr;
  logic        m_actual;
  logic        m_mis;

  tage_hist_queue #(.DEPTH(DEPTH), .GHR_W(GHR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .pred_valid    (pred_valid),
    .pred_pc       (pred_pc),
    .pred_taken    (pred_taken),
    .pred_ready    (pred_ready),
    .ghr           (ghr),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .flush         (flush),
    .train_en      (train_en),
    .train_pc      (train_pc),
    .train_ghr     (train_ghr),
    .actual_taken  (actual_taken),
    .mispredict    (mispredict),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge, written from the queue's behavioural rules.
  task automatic modelEdge(input logic rstn, input logic pv, input logic [31:0] pc,
                           input logic pt, input logic rv, input logic rt, input logic fl);
    bit   ready, push_ok, res_ok, mis;
    ent_t h;
    logic [31:0] repaired;
    if (!rstn) begin
      mq.delete();
      m_spec = 0; m_arch = 0;
      m_train_en = 0; m_train_pc = 0; m_train_ghr = 0; m_actual = 0; m_mis = 0;
      return;
    end
    ready   = (mq.size() != DEPTH);
    push_ok = pv && ready;
    res_ok  = rv && (mq.size() != 0);
    mis     = 0;
    repaired = 0;
    m_train_en = res_ok;
    if (res_ok) begin
      h = mq.pop_front();
      m_train_pc  = h.pc;
      m_train_ghr = h.snap;
      m_actual    = rt;
      repaired    = {h.snap[30:0], rt};
      m_arch      = repaired;
      mis         = (rt != h.pt);
    end
    m_mis = mis;
    if (fl) begin
      mq.delete();
      m_spec = m_arch;
    end else if (mis) begin
      mq.delete();
      m_spec = repaired;
    end else if (push_ok) begin
      mq.push_back('{pc: pc, snap: m_spec, pt: pt});
      m_spec = {m_spec[30:0], pt};
    end
  endtask

  task automatic compareAll();
    checkOutput("count", {28'd0, count}, mq.size());
    checkOutput("ghr", ghr, m_spec);
    checkOutput("pred_ready", {31'd0, pred_ready}, {31'd0, mq.size() != DEPTH});
    checkOutput("train_en", {31'd0, train_en}, {31'd0, m_train_en});
    checkOutput("mispredict", {31'd0, mispredict}, {31'd0, m_mis});
    checkOutput("train_pc", train_pc, m_train_pc);
    checkOutput("train_ghr", train_ghr, m_train_ghr);
    checkOutput("actual_taken", {31'd0, actual_taken}, {31'd0, m_actual});
  endtask

  // Drive one cycle of inputs, advance DUT and model, then compare.
  task automatic applyStimulus(input logic rstn, input logic pv, input logic [31:0] pc,
                               input logic pt, input logic rv, input logic rt, input logic fl);
    @(negedge clk);
    rst = rstn; pred_valid = pv; pred_pc = pc; pred_taken = pt;
    resolve_valid = rv; resolve_taken = rt; flush = fl;
    @(posedge clk);
    modelEdge(rstn, pv, pc, pt, rv, rt, fl);
    #1;
    compareAll();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pushOnly(input logic [31:0] pc, input logic pt);
    applyStimulus(1'b1, 1'b1, pc, pt, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolveOnly(input logic rt);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, rt, 1'b0);
  endtask

  initial begin
    logic rt;
    rst = 1'b0; pred_valid = 0; pred_pc = 0; pred_taken = 0;
    resolve_valid = 0; resolve_taken = 0; flush = 0;

    // Reset values
    doReset();
    checkOutput("reset_ghr", ghr, 32'h0);
    checkOutput("reset_ready", {31'd0, pred_ready}, 32'd1);

    // Three correct predictions
    pushOnly(32'h100, 1'b1);
    pushOnly(32'h104, 1'b0);
    pushOnly(32'h108, 1'b1);
    checkOutput("tnt_ghr", ghr, 32'h5);
    checkOutput("tnt_count", {28'd0, count}, 32'd3);
    resolveOnly(1'b1);
    checkOutput("tnt_train0", train_ghr, 32'h0);
    resolveOnly(1'b0);
    checkOutput("tnt_train1", train_ghr, 32'h1);
    resolveOnly(1'b1);
    checkOutput("tnt_train2", train_ghr, 32'h2);
    checkOutput("tnt_empty", {28'd0, count}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mispredict on the oldest branch
    doReset();
    pushOnly(32'h200, 1'b1);
    pushOnly(32'h204, 1'b1);
    pushOnly(32'h208, 1'b0);
    resolveOnly(1'b0);
    checkOutput("mis_pulse", {31'd0, mispredict}, 32'd1);
    checkOutput("mis_pc", train_pc, 32'h200);
    checkOutput("mis_ghr", ghr, 32'h0);
    pushOnly(32'h20c, 1'b1);
    resolveOnly(1'b1);
    checkOutput("mis_next_snap", train_ghr, 32'h0);

    // Fill, blocked push with pop, then wrap with push/pop pairs
    doReset();
    for (int i = 0; i < DEPTH; i++) pushOnly(32'h300 + 32'(i * 4), i[0]);
    checkOutput("full_ready", {31'd0, pred_ready}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h400, 1'b1, 1'b1, mq[0].pt, 1'b0);
    checkOutput("full_reject", {28'd0, count}, 32'd7);
    for (int i = 0; i < 20; i++) begin
      rt = mq[0].pt;
      applyStimulus(1'b1, 1'b1, 32'h500 + 32'(i * 4), 1'($urandom_range(0, 1)), 1'b1, rt, 1'b0);
    end
    checkOutput("wrap_count", {28'd0, count}, 32'd7);

    // Flush with a simultaneous correct resolve
    doReset();
    pushOnly(32'h600, 1'b1);
    pushOnly(32'h604, 1'b1);
    pushOnly(32'h608, 1'b1);
    pushOnly(32'h60c, 1'b0);
    pushOnly(32'h610, 1'b1);
    resolveOnly(1'b1);
    resolveOnly(1'b1);
    applyStimulus(1'b1, 1'b1, 32'h614, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("flush_train", {31'd0, train_en}, 32'd1);
    checkOutput("flush_count", {28'd0, count}, 32'd0);
    checkOutput("flush_ghr", ghr, 32'h7);

    // Resolve on an empty queue is ignored
    resolveOnly(1'b1);
    checkOutput("empty_train", {31'd0, train_en}, 32'd0);
    checkOutput("empty_mis", {31'd0, mispredict}, 32'd0);
    checkOutput("empty_ghr", ghr, 32'h7);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) pushOnly(32'h700 + 32'(i * 4), 1'b1);
    doReset();
    checkOutput("midrst_count", {28'd0, count}, 32'd0);
    checkOutput("midrst_ghr", ghr, 32'h0);
    checkOutput("midrst_ready", {31'd0, pred_ready}, 32'd1);

    // Randomized traffic; resolves mostly agree with the prediction so the
    // queue gets deep enough to wrap and fill.
    for (int i = 0; i < 400; i++) begin
      logic pv, pt, rv, fl;
      pv = ($urandom_range(0, 99) < 65);
      pt = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 3);
      if (mq.size() != 0 && $urandom_range(0, 99) < 85) rt = mq[0].pt;
      else rt = 1'($urandom_range(0, 1));
      applyStimulus(1'b1, pv, $urandom, pt, rv, rt, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
